// File: rtl/lru_replace_ctrl_pkg.sv
// Shared definitions for the per-set replacement controller:
// policy encodings, LFSR tap mask and a constant log2 helper.
package lru_replace_ctrl_pkg;

    typedef enum logic [1:0] {
        POL_LRU  = 2'b00,
        POL_FIFO = 2'b01,
        POL_RAND = 2'b10,
        POL_RSVD = 2'b11
    } policy_e;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lru_replace_ctrl_lfsr.sv
// Free-running 16-bit Fibonacci LFSR for the random replacement policy;
// exposes only the low OUT_W bits that the caller needs.
module replace_lfsr
    import lru_replace_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned OUT_W = 2
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [OUT_W-1:0] o_rnd
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_rnd = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/lru_replace_ctrl.sv
// Per-set hit/victim way selector: hit way, else first invalid way, else
// LRU / FIFO / random victim. Ages, FIFO pointers kept per set.
module lru_replace_ctrl
    import lru_replace_ctrl_pkg::*;
#(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned SETS      = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned WW = clog2(WAYS),
    localparam int unsigned SW = (SETS > 1) ? clog2(SETS) : 1
)(
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Access,
    input  logic            Flush,
    input  logic [SW-1:0]   SetIdx,
    input  logic [WAYS-1:0] Valid,
    input  logic [WAYS-1:0] Eq,
    input  logic [1:0]      Policy,
    output logic [WW-1:0]   Way,
    output logic            Hit,
    output logic            Done
);

    logic            r_acc;
    logic [SW-1:0]   r_set;
    logic [WAYS-1:0] r_valid;
    logic [WAYS-1:0] r_eq;
    policy_e         r_pol;

    logic [WW-1:0]   r_age  [SETS][WAYS];
    logic [WW-1:0]   r_fifo [SETS];

    logic [WW-1:0]   w_rnd;
    logic            w_hit;
    logic [WW-1:0]   w_hit_way;
    logic [WW-1:0]   w_inv_way;
    logic [WW-1:0]   w_lru_way;
    logic [WW-1:0]   w_sel;
    logic [WW-1:0]   w_sel_age;

    replace_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (WW)
    ) u_lfsr (
        .i_clk   (CLK),
        .i_rst_n (Reset),
        .o_rnd   (w_rnd)
    );

    // Request stage: a flush in the same cycle cancels the access.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_acc   <= 1'b0;
            r_set   <= '0;
            r_valid <= '0;
            r_eq    <= '0;
            r_pol   <= POL_LRU;
        end else begin
            r_acc   <= Access & ~Flush;
            r_set   <= SetIdx;
            r_valid <= Valid;
            r_eq    <= Eq;
            r_pol   <= policy_e'(Policy);
        end
    end

    always_comb begin
        w_hit     = |r_eq;
        w_hit_way = '0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (r_eq[w-1])     w_hit_way = WW'(w - 1);
            if (!r_valid[w-1]) w_inv_way = WW'(w - 1);
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_age[r_set][w] == WW'(WAYS - 1)) w_lru_way = WW'(w);
        end
        if (w_hit) begin
            w_sel = w_hit_way;
        end else if (!(&r_valid)) begin
            w_sel = w_inv_way;
        end else begin
            case (r_pol)
                POL_FIFO: w_sel = r_fifo[r_set];
                POL_RAND: w_sel = w_rnd;
                default:  w_sel = w_lru_way;
            endcase
        end
        w_sel_age = r_age[r_set][w_sel];
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_fifo[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) r_age[s][w] <= WW'(w);
            end
        end else if (Flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_fifo[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) r_age[s][w] <= WW'(w);
            end
        end else if (r_acc) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (r_age[r_set][w] < w_sel_age) r_age[r_set][w] <= r_age[r_set][w] + WW'(1);
            end
            r_age[r_set][w_sel] <= '0;
            if (!w_hit) r_fifo[r_set] <= w_sel + WW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Way  <= '0;
            Hit  <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= r_acc;
            if (r_acc) begin
                Way <= w_sel;
                Hit <= w_hit;
            end
        end
    end

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Scoreboard bench for lru_replace_ctrl (WAYS=4, SETS=16): directed
// vectors push expected results, a negedge monitor pops on Done.
module tb_lru_replace_ctrl;

    logic       clk;
    logic       rst_n;
    logic       Access;
    logic       Flush;
    logic [3:0] SetIdx;
    logic [3:0] Valid;
    logic [3:0] Eq;
    logic [1:0] Policy;
    logic [1:0] Way;
    logic       Hit;
    logic       Done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] way;
        logic       hit;
        string      tag;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_lfsr;

    lru_replace_ctrl #(
        .WAYS      (4),
        .SETS      (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .CLK    (clk),
        .Reset  (rst_n),
        .Access (Access),
        .Flush  (Flush),
        .SetIdx (SetIdx),
        .Valid  (Valid),
        .Eq     (Eq),
        .Policy (Policy),
        .Way    (Way),
        .Hit    (Hit),
        .Done   (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && Done) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".way"}, int'(Way), int'(e.way));
                chk({e.tag, ".hit"}, int'(Hit), int'(e.hit));
            end
        end
    end

    task automatic acc(input logic [3:0] set, input logic [3:0] v, input logic [3:0] e,
                       input logic [1:0] pol, input logic [1:0] xw, input logic xh,
                       input string tag);
        Access = 1'b1;
        SetIdx = set;
        Valid  = v;
        Eq     = e;
        Policy = pol;
        sb.push_back('{way: xw, hit: xh, tag: tag});
        @(negedge clk);
        Access = 1'b0;
    endtask

    task automatic idle(input int n);
        Access = 1'b0;
        Flush  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] nx;
        logic [1:0]  rw;
        logic [3:0]  oh;

        Access = 1'b0;
        Flush  = 1'b0;
        SetIdx = '0;
        Valid  = '0;
        Eq     = '0;
        Policy = 2'b00;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.way",  int'(Way),  0);
        chk("reset.hit",  int'(Hit),  0);
        chk("reset.done", int'(Done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // cold fill
        acc(4'd3, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0, "cold0");
        acc(4'd3, 4'b0001, 4'b0000, 2'b00, 2'd1, 1'b0, "cold1");
        idle(3);

        // LRU ordering on set 5
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            acc(4'd5, 4'b1111, oh, 2'b00, 2'(i), 1'b1, $sformatf("lru_hit%0d", i));
        end
        acc(4'd5, 4'b1111, 4'b0000, 2'b00, 2'd0, 1'b0, "lru_miss_a");
        acc(4'd5, 4'b1111, 4'b0001, 2'b00, 2'd0, 1'b1, "lru_hit0b");
        acc(4'd5, 4'b1111, 4'b0000, 2'b00, 2'd1, 1'b0, "lru_miss_b");
        idle(3);
        chk("hold.way",  int'(Way),  1);
        chk("hold.hit",  int'(Hit),  0);
        chk("hold.done", int'(Done), 0);

        // FIFO on set 7, hits on way 2 interleaved
        for (int i = 0; i < 5; i++) begin
            acc(4'd7, 4'b1111, 4'b0000, 2'b01, 2'(i % 4), 1'b0, $sformatf("fifo_miss%0d", i));
            acc(4'd7, 4'b1111, 4'b0100, 2'b01, 2'd2, 1'b1, $sformatf("fifo_hit%0d", i));
        end
        idle(3);

        // flush colliding with an access
        Flush  = 1'b1;
        Access = 1'b1;
        SetIdx = 4'd5;
        Valid  = 4'b1111;
        Eq     = 4'b0000;
        Policy = 2'b00;
        @(negedge clk);
        Flush  = 1'b0;
        Access = 1'b0;
        chk("flush.done1", int'(Done), 0);
        @(negedge clk);
        chk("flush.done2", int'(Done), 0);
        acc(4'd5, 4'b1111, 4'b0000, 2'b00, 2'd3, 1'b0, "flush_lru_set5");
        acc(4'd7, 4'b1111, 4'b0000, 2'b01, 2'd0, 1'b0, "flush_fifo_set7");
        idle(3);

        // reset between access and result edge
        Access = 1'b1;
        SetIdx = 4'd3;
        Valid  = 4'b0001;
        Eq     = 4'b0000;
        Policy = 2'b00;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        Access = 1'b0;
        @(negedge clk);
        chk("rstmid.done", int'(Done), 0);
        chk("rstmid.way",  int'(Way),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.done_after", int'(Done), 0);

        // random policy, LFSR running since the reset release
        for (int i = 0; i < 8; i++) begin
            nx = lfsr_next(m_lfsr);
            rw = nx[1:0];
            acc(4'd0, 4'b1111, 4'b0000, 2'b10, rw, 1'b0, $sformatf("rand%0d", i));
        end
        acc(4'd0, 4'b1011, 4'b0000, 2'b10, 2'd2, 1'b0, "rand_inv2");
        idle(3);

        // set isolation
        for (int i = 0; i < 20; i++) begin
            rw = 2'($urandom_range(0, 3));
            oh = 4'b0001 << rw;
            acc(4'd2, 4'b1111, oh, 2'b00, rw, 1'b1, $sformatf("set2_hit%0d", i));
        end
        acc(4'd9, 4'b1111, 4'b0000, 2'b00, 2'd3, 1'b0, "set9_victim");
        acc(4'd9, 4'b1111, 4'b0110, 2'b00, 2'd1, 1'b1, "multihot");
        idle(4);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lru_replace_ctrl.md
Name: lru_replace_ctrl

Overview:
Parametrised per-set victim/way selector for an N-way set-associative cache in the MIPS pipeline memory stage. On each access it reports the hit way, or on a miss picks the fill/victim way. Fill order is first invalid way, then LRU, FIFO or pseudo-random according to a runtime policy input. Age, FIFO and LFSR state are kept per set, replacing the earlier single-set, fixed 4-way, LRU-only controller.

Parameters:
WAYS, 4, associativity; power of two, 2..16
SETS, 16, number of sets tracked; power of two, 1..256
LFSR_SEED, 16'hACE1, reset value of the random-policy LFSR; must be nonzero

Ports:
CLK  in  1  clock, all state on posedge
Reset  in  1  asynchronous, active-low reset
Access  in  1  lookup/update strobe, one access per asserted cycle
Flush  in  1  synchronous clear of all replacement state
SetIdx  in  log2(SETS)  set being accessed
Valid  in  WAYS  per-way valid bits of the addressed set
Eq  in  WAYS  per-way tag-match bits, qualified by valid
Policy  in  2  00 LRU, 01 FIFO, 10 random, 11 reserved (treated as LRU)
Way  out  log2(WAYS)  selected way, registered
Hit  out  1  registered, |Eq of the completed access
Done  out  1  one-cycle pulse marking Way/Hit valid

Behaviour:
- Reset (async, Reset=0):
  - Way=0, Hit=0, Done=0.
  - age[s][w]=w for every set, fifo_ptr[s]=0, lfsr=LFSR_SEED.
  - Reset mid-access: the pending result is dropped and Done stays 0.
- Latency: Access sampled at edge k; Way/Hit/Done valid after edge k+1 for one cycle. Back-to-back Access is allowed every cycle. Same-set back-to-back accesses see the state updated by the previous access.
- Selection (combinational from the current set state; result is sel):
  - Hit (|Eq=1): sel = index of the lowest set Eq bit.
  - Else if any Valid=0: sel = lowest-index invalid way.
  - Else LRU: the way with age=WAYS-1.
  - Else FIFO: fifo_ptr[SetIdx].
  - Else random: lfsr[log2(WAYS)-1:0].
- LRU age update, every Access regardless of Policy:
  - Ways with age < age[sel] increment.
  - age[sel] becomes 0.
  - Ages within a set stay a permutation of 0..WAYS-1; no saturation is needed.
- FIFO pointer update:
  - On a miss access, fifo_ptr[SetIdx] = sel+1 mod WAYS.
  - Hits leave the pointer unchanged.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle when not in reset; not affected by Flush.
- Only the addressed set is modified. All other sets hold their state.
- Flush:
  - Restores ages and fifo_ptr for all sets to their reset values in one cycle.
  - Flush has priority over Access in the same cycle: the access is ignored and Done=0 next cycle.
- Hold: with Access=0 and Flush=0, Way and Hit hold their values and Done=0.

Decomposition:
- Shared package holds:
  - a clog2 constant function;
  - policy encodings POL_LRU=2'b00, POL_FIFO=2'b01, POL_RAND=2'b10;
  - the LFSR tap mask.
- One natural sub-module, replace_lfsr: 16-bit LFSR with seed parameter, async active-low reset, always enabled.
- Age and pointer arrays stay in the top level as flop arrays indexed by SetIdx.

Test Plan:
- Cold fill: after reset, SetIdx=3, Valid=0000, Eq=0000, Access -> next cycle Way=0, Hit=0, Done=1. Repeating with Valid=0001 -> Way=1.
- LRU ordering: Policy=00, set 5, Valid=1111:
  - Hits on ways 0,1,2,3 in order, then a miss -> Way=0.
  - Then a hit on way 0, then a miss -> Way=1.
- FIFO: Policy=01, set 7, Valid=1111:
  - Five misses -> Way sequence 0,1,2,3,0.
  - Hits on way 2 interleaved -> sequence unchanged.
- Random: Policy=10, Valid=1111, miss every cycle from reset -> Way equals the low 2 bits of the model LFSR (seed ACE1) each cycle. With Valid=1011 -> Way=2 regardless of the LFSR.
- Flush/reset collisions:
  - Flush and Access in the same cycle -> Done=0, and set 5 ages return to 0,1,2,3.
  - Reset asserted between Access and the result edge -> Done=0, Way=0.
- Set isolation: 20 random accesses to set 2 -> the set 9 LRU victim is still way 3. Multi-hot Eq=0110 -> Way=1, Hit=1.
